// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter: FSM encoding
// and the write-enable value that denotes a read.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic [3:0] WE_READ = 4'h0;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-request picker: returns the winning requester ID.
// On a tie the pointer decides; a lone request always wins.
module dmem_arb_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic ptr_i,
    output logic win_o
);

    assign win_o = (req0_i && req1_i) ? ptr_i : req1_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single asynchronous-read data memory port,
// one access per three cycles. Define DMEM_ARB_RR_EN for round-robin ties.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WADDR = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req_i,
    input  logic             r1_req_i,
    input  logic [3:0]       r0_we_i,
    input  logic [3:0]       r1_we_i,
    input  logic [WADDR-1:0] r0_addr_i,
    input  logic [WADDR-1:0] r1_addr_i,
    input  logic [31:0]      r0_wdata_i,
    input  logic [31:0]      r1_wdata_i,
    output logic             r0_gnt_o,
    output logic             r1_gnt_o,
    output logic             r0_rvalid_o,
    output logic             r1_rvalid_o,
    output logic [31:0]      r0_rdata_o,
    output logic [31:0]      r1_rdata_o,
    output logic             mem_en_o,
    output logic [3:0]       mem_we_o,
    output logic [WADDR-1:0] mem_addr_o,
    output logic [31:0]      mem_data_o,
    input  logic [31:0]      mem_data_i
);

    arb_state_e       state_q, state_d;
    logic             id_q, id_d;
    logic [3:0]       we_q, we_d;
    logic [WADDR-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             win, pick_ptr, acc, resp;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = 1'b0;
`endif

    dmem_arb_pick u_pick (
        .req0_i (r0_req_i),
        .req1_i (r1_req_i),
        .ptr_i  (pick_ptr),
        .win_o  (win)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (r0_req_i || r1_req_i) begin
                    state_d = ACCESS;
                    id_d    = win;
                    we_d    = win ? r1_we_i    : r0_we_i;
                    addr_d  = win ? r1_addr_i  : r0_addr_i;
                    wdata_d = win ? r1_wdata_i : r0_wdata_i;
                end
            end
            ACCESS: begin
                // Async read sees pre-write contents, so writes return old data.
                rdata_d = mem_data_i;
                state_d = RESP;
`ifdef DMEM_ARB_RR_EN
                ptr_d   = ~id_q;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            we_q    <= WE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Reset gates the strobes immediately so an in-flight write never lands.
    assign acc  = (state_q == ACCESS) && !rst;
    assign resp = (state_q == RESP) && !rst;

    assign mem_en_o    = acc;
    assign mem_we_o    = acc ? we_q : WE_READ;
    assign mem_addr_o  = rst ? '0 : addr_q;
    assign mem_data_o  = rst ? '0 : wdata_q;
    assign r0_gnt_o    = acc && !id_q;
    assign r1_gnt_o    = acc && id_q;
    assign r0_rvalid_o = resp && !id_q;
    assign r1_rvalid_o = resp && id_q;
    assign r0_rdata_o  = rst ? '0 : rdata_q;
    assign r1_rdata_o  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a
// transaction-level model. Honours DMEM_ARB_RR_EN like the design.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_v  [2];
    logic [3:0]  we_v   [2];
    logic [9:0]  addr_v [2];
    logic [31:0] wd_v   [2];
    logic        r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, mem_en_o;
    logic [31:0] r0_rdata_o, r1_rdata_o, mem_data_o, mem_data_i;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.WADDR(10)) dut (
        .clk(clk), .rst(rst),
        .r0_req_i(req_v[0]), .r1_req_i(req_v[1]),
        .r0_we_i(we_v[0]), .r1_we_i(we_v[1]),
        .r0_addr_i(addr_v[0]), .r1_addr_i(addr_v[1]),
        .r0_wdata_i(wd_v[0]), .r1_wdata_i(wd_v[1]),
        .r0_gnt_o(r0_gnt_o), .r1_gnt_o(r1_gnt_o),
        .r0_rvalid_o(r0_rvalid_o), .r1_rvalid_o(r1_rvalid_o),
        .r0_rdata_o(r0_rdata_o), .r1_rdata_o(r1_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    // Byte-enabled word memory with asynchronous read.
    assign mem_data_i = mem[mem_addr_o[9:2]];
    initial begin
        for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
        mem[8]  <= 32'h11223344;
        mem[12] <= 32'h55667788;
        forever begin
            @(posedge clk);
            if (mem_en_o)
                for (int b = 0; b < 4; b++)
                    if (mem_we_o[b]) mem[mem_addr_o[9:2]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Transaction model: an accepted request at cycle c grants at c+1,
    // completes at c+2, and the port can accept again at c+3.
    int          cyc = 0, g_cyc = -10, free_cyc = 0;
    bit          w, pref;
    logic [3:0]  lat_we;
    logic [9:0]  lat_addr;
    logic [31:0] lat_wd, exp_rd;
    bit          log_q[$];
    int          obs_rv [2];
    logic [31:0] obs_rd [2];

    function automatic bit pick(bit a, bit b);
        if (a && b) return RR ? pref : 1'b0;
        return !a;
    endfunction

    task automatic cycle();
        bit ig, ir;
        #1;
        ig = (cyc == g_cyc) && !rst;
        ir = (cyc == g_cyc + 1) && !rst;
        if (r0_gnt_o) log_q.push_back(1'b0);
        if (r1_gnt_o) log_q.push_back(1'b1);
        if (r0_rvalid_o) begin obs_rv[0]++; obs_rd[0] = r0_rdata_o; end
        if (r1_rvalid_o) begin obs_rv[1]++; obs_rd[1] = r1_rdata_o; end
        chk("gnt0", {31'b0, r0_gnt_o}, {31'b0, ig && !w});
        chk("gnt1", {31'b0, r1_gnt_o}, {31'b0, ig && w});
        chk("rvalid0", {31'b0, r0_rvalid_o}, {31'b0, ir && !w});
        chk("rvalid1", {31'b0, r1_rvalid_o}, {31'b0, ir && w});
        chk("mem_en", {31'b0, mem_en_o}, {31'b0, ig});
        chk("mem_we", {28'b0, mem_we_o}, ig ? {28'b0, lat_we} : 32'h0);
        chk("mem_addr", {22'b0, mem_addr_o}, rst ? 32'h0 : {22'b0, lat_addr});
        chk("mem_data", mem_data_o, rst ? 32'h0 : lat_wd);
        if (ir) chk("rdata", w ? r1_rdata_o : r0_rdata_o, exp_rd);
        if (rst) begin
            chk("rst_rdata0", r0_rdata_o, 32'h0);
            chk("rst_rdata1", r1_rdata_o, 32'h0);
        end
        if (rst) begin
            g_cyc = -10; free_cyc = cyc + 1; pref = 1'b0; w = 1'b0;
            lat_we = 4'h0; lat_addr = '0; lat_wd = '0;
        end else begin
            if (ig) begin
                exp_rd = ref_mem[lat_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (lat_we[b]) ref_mem[lat_addr[9:2]][b*8 +: 8] = lat_wd[b*8 +: 8];
                pref = !w;
            end
            if (cyc >= free_cyc && (req_v[0] || req_v[1])) begin
                w = pick(req_v[0], req_v[1]);
                lat_we = we_v[w]; lat_addr = addr_v[w]; lat_wd = wd_v[w];
                g_cyc = cyc + 1; free_cyc = cyc + 3;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic req_set(input int i, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        req_v[i] = 1'b1; we_v[i] = we; addr_v[i] = a; wd_v[i] = d;
    endtask

    task automatic req_rand(input int i);
        req_set(i, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                10'h100 + 10'($urandom_range(0, 15) * 4), $urandom);
    endtask

    task automatic req_clr(input int i);
        req_v[i] = 1'b0;
    endtask

    initial begin
        int nv;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 4'h0; addr_v[i] = '0; wd_v[i] = '0;
            obs_rv[i] = 0; obs_rd[i] = '0;
        end
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
        ref_mem[8]  = 32'h11223344;
        ref_mem[12] = 32'h55667788;
        lat_we = 4'h0; lat_addr = '0; lat_wd = '0; exp_rd = '0;

        rst = 1'b1; run(2); rst = 1'b0;

        // Full-word write then readback by the other requester.
        req_set(0, 4'hF, 10'h010, 32'hDEADBEEF); run(2); req_clr(0); run(2);
        req_set(1, 4'h0, 10'h010, 32'h0);        run(2); req_clr(1); run(2);
        chk("rd_deadbeef", obs_rd[1], 32'hDEADBEEF);

        // Single-byte write returns old word, then merged readback.
        req_set(0, 4'b0100, 10'h020, 32'h00AA0000); run(2); req_clr(0); run(2);
        chk("bytewr_old", obs_rd[0], 32'h11223344);
        req_set(0, 4'h0, 10'h020, 32'h0); run(2); req_clr(0); run(2);
        chk("bytewr_rd", obs_rd[0], 32'h11AA3344);

        // Reset lands on the ACCESS cycle of a write: nothing may be written.
        req_set(0, 4'hF, 10'h030, 32'hCAFEF00D); run(1); req_clr(0);
        rst = 1'b1; run(1); rst = 1'b0; run(2);
        chk("rst_nowrite", mem[12], 32'h55667788);

        // Requester drops req right after being latched.
        nv = obs_rv[1];
        req_set(1, 4'h0, 10'h030, 32'h0); run(1); req_clr(1); run(3);
        chk("drop_rvalid", obs_rv[1] - nv, 1);
        chk("drop_rdata", obs_rd[1], 32'h55667788);

        // Both requesters held high across four grants.
        rst = 1'b1; run(1); rst = 1'b0;
        log_q.delete();
        req_set(0, 4'h0, 10'h100, 32'h0); req_set(1, 4'h0, 10'h104, 32'h0);
        run(12); req_clr(0); req_clr(1); run(3);
        chk("order_n", log_q.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("order%0d", k), {31'b0, log_q[k]}, {31'b0, RR && (k % 2 == 1)});

        // Random traffic with legal requester behaviour and occasional resets.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (i == int'(w) && cyc == g_cyc) begin
                    if ($urandom_range(0, 3) == 0) req_clr(i);
                end else if (i == int'(w) && cyc == g_cyc + 1) begin
                    if (req_v[i]) begin
                        if ($urandom_range(0, 1) == 0) req_clr(i); else req_rand(i);
                    end else if ($urandom_range(0, 2) == 0) req_rand(i);
                end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    req_rand(i);
                end
            end
            rst = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0; req_clr(0); req_clr(1); run(4);

        for (int k = 0; k < 256; k++)
            chk($sformatf("mem[%0d]", k), mem[k], ref_mem[k]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
